// File: rtl/pi1_rrarb_pkg.sv
// pi1_rrarb_pkg
//   Shared definitions for the pi1 round-robin arbiter slice:
//   - pi1 op encodings (NOOP/PUTOP/GETOP/RWOP)
//   - arbiter FSM state type
//   - clog2 helper used to size address and grant fields
package pi1_rrarb_pkg;

  // pi1 op encodings
  localparam logic [1:0] PINOOP = 2'd0;  // no operation
  localparam logic [1:0] PIWROP = 2'd1;  // PUTOP: write, completes on accept
  localparam logic [1:0] PIRDOP = 2'd2;  // GETOP: read, completes on data
  localparam logic [1:0] PIRWOP = 2'd3;  // RWOP: swap, completes on data

  // Arbiter sequencing: arbitration, command, optional read-data phase
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  // Ceiling log2; clog2(1) = 0
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/pi1_rrarb_rr_pick.sv
// pi1_rrarb_rr_pick
//   Combinational round-robin priority encoder. Searches req starting at
//   (lst+1) and wrapping modulo N; returns the first set index.
//   Reusable by any arbiter that keeps a last-served pointer.
// Ports:
//   req  in  N   request vector, one bit per requester
//   lst  in  IW  index of the last requester served
//   idx  out IW  next index to serve (0 when vld=0)
//   vld  out 1   at least one request is pending
module pi1_rrarb_rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] lst,
  output logic [IW-1:0] idx,
  output logic          vld
);

  always_comb begin
    int k;
    k   = 0;
    idx = '0;
    vld = 1'b0;
    // Offset 1..N so that lst itself is considered last.
    for (int o = 1; o <= N; o++) begin
      k = (int'(lst) + o) % N;
      if (!vld && req[k]) begin
        idx = k[IW-1:0];
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pi1_rrarb.sv
// pi1_rrarb
//   Single-clock round-robin arbiter sharing one pi1 slave port between
//   MASTERCOUNT pi1 masters. Each transaction runs IDLE (arbitrate) ->
//   CMD (drive slave until accepted) -> DATA (GET/RWOP only, wait for
//   read data). Each master sees exactly one m_rdy_o pulse per transaction.
// Ports:
//   rst_i     in   1                        sync reset, active-high
//   clk_i     in   1                        clock
//   m_op_i    in   2*MASTERCOUNT            per-master op
//   m_addr_i  in   ADDRBITSZ*MASTERCOUNT    per-master address
//   m_data_i  in   ARCHBITSZ*MASTERCOUNT    per-master write data
//   m_sel_i   in   (ARCHBITSZ/8)*MASTERCOUNT per-master byte select
//   m_data_o  out  ARCHBITSZ                read data broadcast (= s_data_i)
//   m_rdy_o   out  MASTERCOUNT              one-hot completion pulse
//   s_op_o    out  2                        slave op
//   s_addr_o  out  ADDRBITSZ                slave address
//   s_data_o  out  ARCHBITSZ                slave write data
//   s_sel_o   out  ARCHBITSZ/8              slave byte select
//   s_data_i  in   ARCHBITSZ                slave read data
//   s_rdy_i   in   1                        slave ready
//   gnt_o     out  GNTBITSZ                 current/last grant index
module pi1_rrarb
  import pi1_rrarb_pkg::*;
#(
  parameter  int MASTERCOUNT = 2,
  parameter  int ARCHBITSZ   = 32,
  localparam int SELBITSZ    = ARCHBITSZ / 8,
  localparam int ADDRBITSZ   = ARCHBITSZ - clog2(ARCHBITSZ / 8),
  localparam int GNTBITSZ    = (clog2(MASTERCOUNT) < 1) ? 1 : clog2(MASTERCOUNT)
) (
  input  logic                               rst_i,
  input  logic                               clk_i,
  input  logic [2*MASTERCOUNT-1:0]           m_op_i,
  input  logic [ADDRBITSZ*MASTERCOUNT-1:0]   m_addr_i,
  input  logic [ARCHBITSZ*MASTERCOUNT-1:0]   m_data_i,
  input  logic [SELBITSZ*MASTERCOUNT-1:0]    m_sel_i,
  output logic [ARCHBITSZ-1:0]               m_data_o,
  output logic [MASTERCOUNT-1:0]             m_rdy_o,
  output logic [1:0]                         s_op_o,
  output logic [ADDRBITSZ-1:0]               s_addr_o,
  output logic [ARCHBITSZ-1:0]               s_data_o,
  output logic [SELBITSZ-1:0]                s_sel_o,
  input  logic [ARCHBITSZ-1:0]               s_data_i,
  input  logic                               s_rdy_i,
  output logic [GNTBITSZ-1:0]                gnt_o
);

  // Per-master views of the flattened request buses
  logic [MASTERCOUNT-1:0][1:0]           op_a;
  logic [MASTERCOUNT-1:0][ADDRBITSZ-1:0] addr_a;
  logic [MASTERCOUNT-1:0][ARCHBITSZ-1:0] data_a;
  logic [MASTERCOUNT-1:0][SELBITSZ-1:0]  sel_a;
  logic [MASTERCOUNT-1:0]                req;

  assign op_a   = m_op_i;
  assign addr_a = m_addr_i;
  assign data_a = m_data_i;
  assign sel_a  = m_sel_i;

  for (genvar k = 0; k < MASTERCOUNT; k++) begin : g_req
    assign req[k] = (op_a[k] != PINOOP);
  end

  // State
  state_t                state_q;
  logic [GNTBITSZ-1:0]   gnt_q;
  logic [GNTBITSZ-1:0]   lst_q;

  // Round-robin choice, only consumed in IDLE
  logic [GNTBITSZ-1:0]   pick_idx;
  logic                  pick_vld;

  pi1_rrarb_rr_pick #(
    .N  (MASTERCOUNT),
    .IW (GNTBITSZ)
  ) u_pick (
    .req (req),
    .lst (lst_q),
    .idx (pick_idx),
    .vld (pick_vld)
  );

  // Granted master's fields. Written as a compare loop so the mux stays
  // clean for any MASTERCOUNT, including non-powers of two and 1.
  logic [1:0]           g_op;
  logic [ADDRBITSZ-1:0] g_addr;
  logic [ARCHBITSZ-1:0] g_data;
  logic [SELBITSZ-1:0]  g_sel;

  always_comb begin
    g_op   = PINOOP;
    g_addr = '0;
    g_data = '0;
    g_sel  = '0;
    for (int k = 0; k < MASTERCOUNT; k++) begin
      if (gnt_q == GNTBITSZ'(k)) begin
        g_op   = op_a[k];
        g_addr = addr_a[k];
        g_data = data_a[k];
        g_sel  = sel_a[k];
      end
    end
  end

  // Completion: a PUT finishes on command accept, reads finish on data.
  logic in_cmd, in_data, done;

  assign in_cmd  = (state_q == ST_CMD);
  assign in_data = (state_q == ST_DATA);
  assign done    = s_rdy_i & ((in_cmd & (g_op == PIWROP)) | in_data);

  always_comb begin
    m_rdy_o = '0;
    for (int k = 0; k < MASTERCOUNT; k++) begin
      m_rdy_o[k] = done & (gnt_q == GNTBITSZ'(k));
    end
  end

  // Slave side. A withdrawn request (op back to NOOP in CMD) naturally
  // drives NOOP here, so the slave never sees a half-issued command.
  assign s_op_o   = in_cmd ? g_op : PINOOP;
  assign s_addr_o = g_addr;
  assign s_data_o = g_data;
  assign s_sel_o  = g_sel;

  assign m_data_o = s_data_i;
  assign gnt_o    = gnt_q;

  // lst_q resets to the top index so master 0 wins the first arbitration.
  // lst_q only advances on completion; a withdrawal leaves order untouched.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      lst_q   <= GNTBITSZ'(MASTERCOUNT - 1);
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_vld) begin
            gnt_q   <= pick_idx;
            state_q <= ST_CMD;
          end
        end
        ST_CMD: begin
          if (g_op == PINOOP) begin
            state_q <= ST_IDLE;
          end else if (s_rdy_i) begin
            if (g_op == PIWROP) begin
              lst_q   <= gnt_q;
              state_q <= ST_IDLE;
            end else begin
              state_q <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (s_rdy_i) begin
            lst_q   <= gnt_q;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
